rom_download_loader: RTL and testbench
======================================

// Module: rom_download_loader
// PURPOSE
// Sits between hps_io's 16-bit ioctl download stream and the core's byte-wide ROM/PROM RAMs.
// Serialises each 16-bit ioctl word into two byte writes and decodes the byte address into one of four regions.
// Also captures DIP bytes (ioctl_index 254) and holds the core in reset while a ROM download is active.
// Downstream: the core ROM RAMs and the dsw input; upstream: hps_io ioctl_* signals.
// PARAMETERS
// CPU_END   24'h0E000  first byte address past the CPU program ROM region (region 0)
// FG_END    24'h12000  first byte address past the FG tile ROM region (region 1)
// BG_END    24'h16000  first byte address past the BG tile ROM region (region 2)
// PROM_END  24'h16220  first byte address past the colour PROM region (region 3); total image size
// PORTS
// clk_sys         in   1   system clock; every register updates on its rising edge
// reset           in   1   synchronous, active-high reset
// ioctl_download  in   1   download in progress (any index)
// ioctl_index     in   8   0 = ROM image, 254 = DIP switches; all other values ignored
// ioctl_wr        in   1   one-cycle write strobe for the current word
// ioctl_addr      in   27  byte address of the word's low byte (always even)
// ioctl_dout      in   16  [7:0] = byte at addr, [15:8] = byte at addr+1
// ioctl_wait      out  1   stall request to hps_io while the word is being written
// rom_addr        out  16  byte offset inside the selected region
// rom_data        out  8   byte to write
// rom_we          out  4   one-hot region write enable, [0]=CPU [1]=FG [2]=BG [3]=PROM
// dsw             out  8   DIP byte 0
// core_reset      out  1   reset to core: reset | ROM download active | 1 cycle after it ends
// dl_done         out  1   one-cycle pulse when an index-0 download ends
// overflow        out  1   sticky: at least one byte addressed at or past PROM_END
// BEHAVIOUR
// - Reset values: ioctl_wait=0, rom_we=0, rom_addr=0, rom_data=0, dsw=8'h00, dl_done=0, overflow=0; FSM=IDLE.
// - core_reset is combinational on reset (=1 during reset) and registered otherwise.
// - FSM: IDLE -> LO -> HI -> IDLE.
//   IDLE: ioctl_wr && ioctl_download && index==0 latches addr/dout, sets ioctl_wait=1, goes to LO.
//   LO: drives byte addr, data dout[7:0], pulses rom_we for 1 cycle; goes to HI.
//   HI: drives byte addr+1, data dout[15:8], pulses rom_we for 1 cycle; clears ioctl_wait; goes to IDLE.
// - Latency: the low-byte write is 1 cycle after ioctl_wr and the high-byte write is 2 cycles after it.
//   ioctl_wait is high for exactly 2 cycles per word.
// - Region decode per byte address A: A<CPU_END -> region 0, offset A.
//   A<FG_END -> region 1, offset A-CPU_END. A<BG_END -> region 2, offset A-FG_END.
//   A<PROM_END -> region 3, offset A-BG_END. Otherwise there is no write (rom_we=0) and overflow is set.
// - Decode is per byte, so a word straddling a boundary writes its two bytes to different regions.
// - ioctl_wr while the FSM is not IDLE is ignored; hps_io honours ioctl_wait, so this is legal only as a fault.
// - DIP: ioctl_wr with index==254 and ioctl_addr[26:3]==0 and ioctl_addr[2:0]==0 loads dsw<=ioctl_dout[7:0] on the next edge.
//   DIP writes need no FSM and no ioctl_wait. Other DIP addresses are ignored.
// - Download-active flag: set when ioctl_download && index==0.
//   On its falling edge: dl_done pulses 1 cycle, and core_reset is held 1 extra cycle.
// - If download drops while the FSM is in LO or HI, the pending byte(s) are still written; dl_done fires after the FSM returns to IDLE.
// - overflow clears only on reset or at the rising edge of a new index-0 download.
// - reset mid-word: the FSM returns to IDLE, ioctl_wait=0 and no further rom_we is issued for that word.
// TESTING
// 1. Word 16'hA55A at addr 0 -> rom_we=4'b0001/addr 0/data 5A at T+1; addr 1/data A5 at T+2; ioctl_wait high T+1..T+2 only.
// 2. Word at addr 24'h0DFFE, then 24'h0E000 -> bytes 0DFFE/0DFFF go to region 0; byte 0E000 goes to region 1 with rom_addr=0.
// 3. Word at addr 24'h1621F -> byte 1621F goes to region 3 with offset 21F; byte 16220 produces no rom_we and overflow=1.
//    overflow stays 1 until the next download starts.
// 4. index=254, addr 0, dout 16'h00C3 -> dsw=8'hC3 next cycle with no ioctl_wait; the same write at addr 1 leaves dsw unchanged.
// 5. ioctl_download 1->0 -> dl_done is a single pulse; core_reset stays high 1 cycle past the drop, then 0.
// 6. reset asserted in state LO -> no HI write occurs; ioctl_wait=0, rom_we=0 and dsw=00 on the next cycle.

Source files
------------

// File: rtl/rom_download_loader.sv
// Turns the 16-bit ioctl download stream into byte writes for four ROM regions.
// It also captures the DIP byte and holds the core in reset while a ROM image is loading.
module rom_download_loader #(
    parameter logic [23:0] CPU_END  = 24'h0E000,
    parameter logic [23:0] FG_END   = 24'h12000,
    parameter logic [23:0] BG_END   = 24'h16000,
    parameter logic [23:0] PROM_END = 24'h16220
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [26:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    output logic        ioctl_wait,
    output logic [15:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic [3:0]  rom_we,
    output logic [7:0]  dsw,
    output logic        core_reset,
    output logic        dl_done,
    output logic        overflow
);
    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    // Exclusive upper bound of each region; element 0 is the CPU region.
    localparam logic [3:0][26:0] UPPER = {{3'b0, PROM_END}, {3'b0, BG_END},
                                          {3'b0, FG_END}, {3'b0, CPU_END}};

    state_t      state_reg;
    logic [26:0] addr_reg;
    logic [7:0]  hi_data_reg;
    logic        dl_active_reg;
    logic        core_reset_reg;

    logic        rom_dl;
    logic        dip_wr;
    logic [26:0] byte_addr;
    logic [3:0]  below;
    logic [3:0]  hit;
    logic [15:0] off_vec [4];
    logic [15:0] byte_off;
    logic        byte_ovf;

    assign rom_dl     = ioctl_download && (ioctl_index == 8'd0);
    assign dip_wr     = ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr == 27'd0);
    assign core_reset = reset || core_reset_reg;

    // Only one byte is decoded per cycle: the incoming low byte, or the latched high byte.
    assign byte_addr = (state_reg == LO) ? (addr_reg + 27'd1) : ioctl_addr;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_region
            assign below[gi] = byte_addr < UPPER[gi];
            if (gi == 0) begin : g_first
                assign hit[gi]     = below[gi];
                assign off_vec[gi] = byte_addr[15:0];
            end else begin : g_rest
                logic [26:0] rel;
                assign rel         = byte_addr - UPPER[gi-1];
                assign hit[gi]     = below[gi] && !below[gi-1];
                assign off_vec[gi] = rel[15:0];
            end
        end
    endgenerate

    assign byte_ovf = !below[3];

    always_comb begin
        byte_off = 16'd0;
        for (int i = 0; i < 4; i++) begin
            if (hit[i]) begin
                byte_off = off_vec[i];
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            hi_data_reg    <= '0;
            ioctl_wait     <= 1'b0;
            rom_we         <= '0;
            rom_addr       <= '0;
            rom_data       <= '0;
            dsw            <= 8'h00;
            dl_done        <= 1'b0;
            overflow       <= 1'b0;
            dl_active_reg  <= 1'b0;
            core_reset_reg <= 1'b0;
        end else begin
            rom_we         <= '0;
            dl_done        <= 1'b0;
            core_reset_reg <= rom_dl || dl_active_reg;

            if (dip_wr) begin
                dsw <= ioctl_dout[7:0];
            end
            if (rom_dl && !dl_active_reg) begin
                overflow <= 1'b0;
            end
            // The active flag outlives the download until the pending high byte is out.
            if (rom_dl) begin
                dl_active_reg <= 1'b1;
            end else if (dl_active_reg && state_reg == IDLE) begin
                dl_active_reg <= 1'b0;
                dl_done       <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (ioctl_wr && rom_dl) begin
                        addr_reg    <= ioctl_addr;
                        hi_data_reg <= ioctl_dout[15:8];
                        rom_we      <= hit;
                        rom_addr    <= byte_off;
                        rom_data    <= ioctl_dout[7:0];
                        ioctl_wait  <= 1'b1;
                        if (byte_ovf) begin
                            overflow <= 1'b1;
                        end
                        state_reg   <= LO;
                    end
                end
                LO: begin
                    rom_we    <= hit;
                    rom_addr  <= byte_off;
                    rom_data  <= hi_data_reg;
                    if (byte_ovf) begin
                        overflow <= 1'b1;
                    end
                    state_reg <= HI;
                end
                HI: begin
                    ioctl_wait <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_download_loader.sv
// Randomised bench for rom_download_loader: a queue-of-bytes reference model checked every cycle,
// plus directed scenarios pinned to hand-computed values.
module tb_rom_download_loader;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [26:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wait;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic [3:0]  rom_we;
    logic [7:0]  dsw;
    logic        core_reset;
    logic        dl_done;
    logic        overflow;

    int vectors = 0;
    int miscompares = 0;

    rom_download_loader dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .rom_addr(rom_addr),
        .rom_data(rom_data), .rom_we(rom_we), .dsw(dsw), .core_reset(core_reset),
        .dl_done(dl_done), .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [26:0] a;
        logic [7:0]  d;
    } byte_t;

    byte_t       q[$];
    byte_t       b;
    bit          m_valid = 0;
    bit          tail, idle, cur;
    logic        m_wait, m_done, m_ovf, m_active, m_cr, m_addr_chk;
    logic [3:0]  m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_data, m_dsw;

    task automatic emit(input byte_t x);
        m_data = x.d;
        m_addr_chk = 1'b1;
        if (x.a < 27'h0E000)      begin m_we = 4'b0001; m_addr = 16'(x.a); end
        else if (x.a < 27'h12000) begin m_we = 4'b0010; m_addr = 16'(x.a - 27'h0E000); end
        else if (x.a < 27'h16000) begin m_we = 4'b0100; m_addr = 16'(x.a - 27'h12000); end
        else if (x.a < 27'h16220) begin m_we = 4'b1000; m_addr = 16'(x.a - 27'h16000); end
        else begin m_we = 4'b0000; m_ovf = 1'b1; m_addr_chk = 1'b0; end
    endtask

    always @(posedge clk_sys) begin
        cur = ioctl_download && ioctl_index == 8'd0;
        if (reset) begin
            m_valid = 1; q.delete(); tail = 0;
            m_wait = 0; m_we = 0; m_addr = 0; m_data = 0; m_addr_chk = 1;
            m_dsw = 0; m_ovf = 0; m_done = 0; m_active = 0; m_cr = 0;
        end else begin
            m_we = 0; m_addr_chk = 0; m_done = 0;
            idle = (q.size() == 0) && !tail;
            tail = 0;
            m_cr = cur || m_active;
            if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr == 27'd0) m_dsw = ioctl_dout[7:0];
            if (cur && !m_active) m_ovf = 0;
            if (cur) m_active = 1;
            else if (m_active && idle) begin m_active = 0; m_done = 1; end
            if (q.size() > 0) begin
                b = q.pop_front(); emit(b);
                if (q.size() == 0) tail = 1;
                m_wait = 1;
            end else if (idle && ioctl_wr && cur) begin
                q.push_back('{a: ioctl_addr, d: ioctl_dout[7:0]});
                q.push_back('{a: ioctl_addr + 27'd1, d: ioctl_dout[15:8]});
                b = q.pop_front(); emit(b);
                m_wait = 1;
            end else begin
                m_wait = 0;
            end
        end
    end

    always @(negedge clk_sys) begin
        if (m_valid) begin
            chk("ioctl_wait", ioctl_wait, m_wait);
            chk("rom_we", rom_we, m_we);
            if (m_addr_chk) begin
                chk("rom_addr", rom_addr, m_addr);
                chk("rom_data", rom_data, m_data);
            end
            chk("dsw", dsw, m_dsw);
            chk("overflow", overflow, m_ovf);
            chk("dl_done", dl_done, m_done);
            chk("core_reset", core_reset, reset | m_cr);
        end
    end

    // ---------------- stimulus ----------------
    logic [3:0]  o_we [2];
    logic [15:0] o_addr [2];
    logic [7:0]  o_data [2];
    logic        o_wait [3];

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic word(input logic [26:0] a, input logic [15:0] d);
        ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        o_we[0] = rom_we; o_addr[0] = rom_addr; o_data[0] = rom_data; o_wait[0] = ioctl_wait;
        tick();
        o_we[1] = rom_we; o_addr[1] = rom_addr; o_data[1] = rom_data; o_wait[1] = ioctl_wait;
        tick();
        o_wait[2] = ioctl_wait;
    endtask

    function automatic logic [26:0] rand_addr();
        logic [26:0] base;
        int sel;
        sel = $urandom_range(0, 6);
        case (sel)
            0: base = 27'h0E000;
            1: base = 27'h12000;
            2: base = 27'h16000;
            3: base = 27'h16220;
            4: base = 27'h00000;
            5: base = 27'(($urandom_range(0, 27'h17000)));
            default: base = 27'($urandom) | 27'h4000000;
        endcase
        base = base + 27'($urandom_range(0, 16)) - 27'd8;
        return {base[26:1], 1'b0};
    endfunction

    initial begin
        reset = 1; ioctl_download = 0; ioctl_index = 0; ioctl_wr = 0;
        ioctl_addr = 0; ioctl_dout = 0;
        repeat (3) tick();
        chk("reset rom_we", rom_we, 4'b0000);
        chk("reset core_reset", core_reset, 1'b1);
        chk("reset dsw", dsw, 8'h00);
        reset = 0;
        ioctl_download = 1; ioctl_index = 0;
        tick();
        chk("dl core_reset", core_reset, 1'b1);

        // word at address 0
        word(27'h0, 16'hA55A);
        chk("w0 lo we", o_we[0], 4'b0001);
        chk("w0 lo addr", o_addr[0], 16'h0000);
        chk("w0 lo data", o_data[0], 8'h5A);
        chk("w0 hi addr", o_addr[1], 16'h0001);
        chk("w0 hi data", o_data[1], 8'hA5);
        chk("w0 wait", {o_wait[0], o_wait[1], o_wait[2]}, 3'b110);

        // CPU/FG boundary
        word(27'h0DFFE, 16'h1122);
        chk("b0 lo we", o_we[0], 4'b0001);
        chk("b0 hi addr", o_addr[1], 16'hDFFF);
        word(27'h0E000, 16'h3344);
        chk("b1 lo we", o_we[0], 4'b0010);
        chk("b1 lo addr", o_addr[0], 16'h0000);

        // PROM end straddle
        word(27'h1621F, 16'h5678);
        chk("p lo we", o_we[0], 4'b1000);
        chk("p lo addr", o_addr[0], 16'h021F);
        chk("p lo data", o_data[0], 8'h78);
        chk("p hi we", o_we[1], 4'b0000);
        chk("p overflow", overflow, 1'b1);

        // end of download
        ioctl_download = 0;
        tick();
        chk("drop dl_done", dl_done, 1'b1);
        chk("drop core_reset", core_reset, 1'b1);
        tick();
        chk("after dl_done", dl_done, 1'b0);
        chk("after core_reset", core_reset, 1'b0);
        chk("ovf sticky", overflow, 1'b1);

        // DIP switches
        ioctl_download = 1; ioctl_index = 8'd254;
        ioctl_addr = 0; ioctl_dout = 16'h00C3; ioctl_wr = 1;
        tick();
        chk("dip dsw", dsw, 8'hC3);
        chk("dip wait", ioctl_wait, 1'b0);
        ioctl_addr = 27'd1; ioctl_dout = 16'h0011;
        tick();
        ioctl_wr = 0;
        chk("dip addr1 dsw", dsw, 8'hC3);

        // new ROM download clears overflow; reset during LO
        ioctl_index = 0;
        tick();
        chk("ovf cleared", overflow, 1'b0);
        ioctl_addr = 27'h100; ioctl_dout = 16'hBEEF; ioctl_wr = 1;
        tick();
        ioctl_wr = 0;
        chk("r lo we", rom_we, 4'b0001);
        reset = 1;
        tick();
        chk("r wait", ioctl_wait, 1'b0);
        chk("r we", rom_we, 4'b0000);
        chk("r dsw", dsw, 8'h00);
        reset = 0;
        tick();
        chk("r no hi", rom_we, 4'b0000);

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) ioctl_download = !ioctl_download;
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 5))
                    0: ioctl_index = 8'd254;
                    1: ioctl_index = 8'($urandom_range(1, 253));
                    default: ioctl_index = 8'd0;
                endcase
            end
            ioctl_wr = ($urandom_range(0, 2) == 0);
            ioctl_dout = 16'($urandom);
            if (ioctl_index == 8'd254) ioctl_addr = 27'($urandom_range(0, 3));
            else ioctl_addr = rand_addr();
            tick();
        end
        reset = 0; ioctl_wr = 0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
